// File: rtl/turbo_encoder_core.sv
// turbo_encoder_core: rate-1/3 turbo encoder (two 8-state RSC encoders, ck1 bit FIFO); define TRELLIS_TAIL_EN for trellis termination.
// One cycle from step to out_valid; an unaccepted output word stalls FIFO pops and ck2 until out_ready.

module turbo_bit_fifo #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        din_i,
  input  logic        pop_i,
  output logic        dout_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] used_o
);
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      used_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (used_q == (AW+1)'(DEPTH));
  assign empty_o = (used_q == '0);
  // a full FIFO refuses the push even when a pop frees a slot in the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign used_o  = used_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   used_q <= used_q + (AW+1)'(1);
        2'b01:   used_q <= used_q - (AW+1)'(1);
        default: used_q <= used_q;
      endcase
    end
  end
endmodule

module turbo_encoder_core #(
  parameter int KMAX       = 6144,
  parameter int KMIN       = 40,
  parameter int KW         = 13,
  parameter int FIFO_DEPTH = 512,
  parameter int AW         = 9
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          start,
  input  logic [KW-1:0] blk_len,
  input  logic          ck1,
  input  logic          ck1_valid,
  output logic          ck1_ready,
  input  logic          ck2,
  input  logic          ck2_valid,
  output logic          ck2_ready,
  output logic          d0,
  output logic          d1,
  output logic          d2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic [AW:0]   fifo_used
);
  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt_q;
  logic [2:0]    enc1_q;     // {s1,s2,s3}, s1 newest
  logic [2:0]    enc2_q;
  logic [2:0]    d_q;
  logic          out_valid_q;
  logic          err_len_q;
`ifdef TRELLIS_TAIL_EN
  logic [11:0]   tail_q;
  logic [2:0]    tcnt_q;
  logic          tail_load;
`endif

  logic          fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          out_free;
  logic          step;
  logic          len_ok;
  logic [3:0]    r1_d;
  logic [3:0]    r2_d;

  // returns {z, next state}
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a ^ s[2] ^ s[0], a, s[2], s[1]};
  endfunction

  // three termination steps from state s: {x1,z1,x2,z2,x3,z3}; the input x cancels the feedback
  function automatic logic [5:0] rsc_tail(input logic [2:0] s);
    logic [2:0] st;
    logic [5:0] bits;
    st   = s;
    bits = '0;
    for (int i = 0; i < 3; i++) begin
      bits[5-2*i] = st[1] ^ st[0];
      bits[4-2*i] = st[2] ^ st[0];
      st = {1'b0, st[2], st[1]};
    end
    return bits;
  endfunction

  turbo_bit_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_ck1_fifo (
    .clk     (clk),
    .rst     (aclr),
    .push_i  (ck1_valid),
    .din_i   (ck1),
    .pop_i   (step),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .used_o  (fifo_used)
  );

  assign out_free = ~out_valid_q | out_ready;
  assign step     = (state_q == ENC) && (cnt_q != k_q) && !fifo_empty && ck2_valid && out_free;
  assign len_ok   = (blk_len >= KW'(KMIN)) && (blk_len <= KW'(KMAX));
  assign r1_d     = rsc_step(enc1_q, fifo_dout);
  assign r2_d     = rsc_step(enc2_q, ck2);
`ifdef TRELLIS_TAIL_EN
  assign tail_load = (state_q == TAIL) && (tcnt_q != 3'd4) && out_free;
`endif

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      enc1_q      <= '0;
      enc2_q      <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
`ifdef TRELLIS_TAIL_EN
      tail_q      <= '0;
      tcnt_q      <= '0;
`endif
    end else begin
      err_len_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q <= ENC;
              k_q     <= blk_len;
              cnt_q   <= '0;
              enc1_q  <= '0;
              enc2_q  <= '0;
            end else begin
              err_len_q <= 1'b1;
            end
          end
        end
        ENC: begin
          if (step) begin
            enc1_q      <= r1_d[2:0];
            enc2_q      <= r2_d[2:0];
            d_q         <= {fifo_dout, r1_d[3], r2_d[3]};
            out_valid_q <= 1'b1;
            cnt_q       <= cnt_q + KW'(1);
          end else if (cnt_q == k_q) begin
`ifdef TRELLIS_TAIL_EN
            state_q <= TAIL;
            tail_q  <= {rsc_tail(enc1_q), rsc_tail(enc2_q)};
            tcnt_q  <= '0;
            enc1_q  <= '0;
            enc2_q  <= '0;
`else
            // leave only once the last word has been taken
            if (out_free) state_q <= DONE;
`endif
          end
        end
        TAIL: begin
`ifdef TRELLIS_TAIL_EN
          if (tail_load) begin
            d_q         <= tail_q[11:9];
            tail_q      <= {tail_q[8:0], 3'b000};
            tcnt_q      <= tcnt_q + 3'd1;
            out_valid_q <= 1'b1;
          end else if ((tcnt_q == 3'd4) && out_free) begin
            state_q <= DONE;
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ck1_ready = ~fifo_full;
  assign ck2_ready = step;
  assign d0        = d_q[2];
  assign d1        = d_q[1];
  assign d2        = d_q[0];
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err_len   = err_len_q;
endmodule
